// File: rtl/axis_packet_router_if.sv
// AXI4-Stream beat channel (valid/last/data/ready) used for the router input and both outputs.
// master drives the beat, slave returns ready.
interface axis_packet_router_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  tvalid;
    logic                  tlast;
    logic [DATA_WIDTH-1:0] tdata;
    logic                  tready;

    modport master (
        output tvalid,
        output tlast,
        output tdata,
        input  tready
    );

    modport slave (
        input  tvalid,
        input  tlast,
        input  tdata,
        output tready
    );
endinterface

// File: rtl/axis_packet_router.sv
// Packet-granular 1:2 AXI4-Stream splitter: header bits [MSB:MSB-1] pick A, B or drop,
// forwarded beats pass through one shared registered output slice, drops are counted.
module axis_packet_router #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    axis_packet_router_if.slave  K,
    axis_packet_router_if.master A,
    axis_packet_router_if.master B,
    output logic [CNT_WIDTH-1:0] drop_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FWD_A = 2'd1,
        FWD_B = 2'd2,
        DROP  = 2'd3
    } state_t;

    state_t                state;
    state_t                state_nxt;
    state_t                route;

    logic                  slice_vld_p1;
    logic                  slice_dest_p1;
    logic                  slice_last_p1;
    logic [DATA_WIDTH-1:0] slice_data_p1;

    logic                  slice_ready;
    logic                  is_drop;
    logic                  k_ready;
    logic                  accept;
    logic                  load;
    logic [1:0]            route_field;

    function automatic state_t decode_route(input logic [1:0] field);
        if (field[1]) begin
            return DROP;
        end else if (field[0]) begin
            return FWD_B;
        end else begin
            return FWD_A;
        end
    endfunction

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] value);
        if (&value) begin
            return value;
        end else begin
            return value + CNT_WIDTH'(1);
        end
    endfunction

    assign route_field = K.tdata[DATA_WIDTH-1 -: 2];

    // In IDLE the incoming beat is a header, so its route is decoded live; otherwise it is locked.
    always_comb begin
        route       = state;
        slice_ready = 1'b0;
        if (state == IDLE) begin
            route = decode_route(route_field);
        end
        is_drop     = (route == DROP);
        slice_ready = slice_dest_p1 ? B.tready : A.tready;
        k_ready     = is_drop | ~slice_vld_p1 | slice_ready;
        accept      = K.tvalid & k_ready;
        load        = accept & ~is_drop;
    end

    assign K.tready = k_ready;

    always_comb begin
        state_nxt = state;
        if (accept) begin
            if (K.tlast) begin
                state_nxt = IDLE;
            end else begin
                state_nxt = route;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // p0 -> p1: accepted beat enters the shared output slice; a drain and a load may coincide.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            slice_vld_p1  <= 1'b0;
            slice_dest_p1 <= 1'b0;
            slice_last_p1 <= 1'b0;
            slice_data_p1 <= '0;
        end else if (load) begin
            slice_vld_p1  <= 1'b1;
            slice_dest_p1 <= (route == FWD_B);
            slice_last_p1 <= K.tlast;
            slice_data_p1 <= K.tdata;
        end else if (slice_ready) begin
            slice_vld_p1  <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            drop_count <= '0;
        end else if (accept && is_drop && (state == IDLE)) begin
            drop_count <= sat_inc(drop_count);
        end
    end

    assign A.tvalid = slice_vld_p1 & ~slice_dest_p1;
    assign A.tlast  = slice_vld_p1 & ~slice_dest_p1 & slice_last_p1;
    assign A.tdata  = slice_data_p1;
    assign B.tvalid = slice_vld_p1 & slice_dest_p1;
    assign B.tlast  = slice_vld_p1 & slice_dest_p1 & slice_last_p1;
    assign B.tdata  = slice_data_p1;

endmodule

// File: tb/tb_axis_packet_router.sv
// Directed scenarios followed by randomized packets scored against a packet-level reference model.
module tb_axis_packet_router;
    localparam int DW = 8;
    localparam int CW = 8;

    typedef struct packed {
        logic [7:0] d;
        logic       l;
        logic [1:0] dst;
        logic       hdr;
    } beat_t;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [CW-1:0] drop_count;
    int            checks = 0;
    int            failures = 0;

    axis_packet_router_if #(.DATA_WIDTH(DW)) k_if ();
    axis_packet_router_if #(.DATA_WIDTH(DW)) a_if ();
    axis_packet_router_if #(.DATA_WIDTH(DW)) b_if ();

    axis_packet_router #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .clk        (clk),
        .reset      (reset),
        .K          (k_if),
        .A          (a_if),
        .B          (b_if),
        .drop_count (drop_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic beat(input logic v, input logic l, input logic [7:0] d);
        k_if.tvalid = v;
        k_if.tlast  = l;
        k_if.tdata  = d;
        #1;
    endtask

    task automatic nxt();
        @(negedge clk);
        #1;
    endtask

    logic [7:0] t2_data [3] = '{8'h05, 8'h11, 8'h22};
    beat_t      stim [$];
    logic [9:0] expq [$];

    initial begin
        int         si;
        int         cyc;
        int         dc_exp;
        logic       held;
        logic       ka;
        logic       pa_stall, pb_stall;
        logic [8:0] pa_beat, pb_beat;
        logic [7:0] hdr;
        logic [7:0] d;
        int         len;
        beat_t      bt;

        k_if.tvalid = 1'b0;
        k_if.tlast  = 1'b0;
        k_if.tdata  = '0;
        a_if.tready = 1'b0;
        b_if.tready = 1'b0;

        // Reset low for three cycles, then released with K idle
        repeat (3) @(negedge clk);
        reset = 1'b1;
        nxt();
        chk("rst_a_tvalid", a_if.tvalid, 0);
        chk("rst_a_tlast", a_if.tlast, 0);
        chk("rst_a_tdata", a_if.tdata, 0);
        chk("rst_b_tvalid", b_if.tvalid, 0);
        chk("rst_b_tlast", b_if.tlast, 0);
        chk("rst_b_tdata", b_if.tdata, 0);
        chk("rst_drop_count", drop_count, 0);
        chk("rst_k_tready", k_if.tready, 1);

        // Three-beat packet to A, each beat one cycle after acceptance
        a_if.tready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            beat(1'b1, i == 2, t2_data[i]);
            chk("a_pkt_k_tready", k_if.tready, 1);
            nxt();
            chk("a_pkt_tvalid", a_if.tvalid, 1);
            chk("a_pkt_tdata", a_if.tdata, t2_data[i]);
            chk("a_pkt_tlast", a_if.tlast, (i == 2) ? 1 : 0);
            chk("a_pkt_b_tvalid", b_if.tvalid, 0);
        end
        beat(1'b0, 1'b0, 8'h00);
        nxt();
        chk("a_pkt_idle", a_if.tvalid, 0);

        // Header to B held by backpressure, then drained once
        b_if.tready = 1'b0;
        beat(1'b1, 1'b1, 8'h45);
        nxt();
        beat(1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 3; i++) begin
            chk("b_hold_tvalid", b_if.tvalid, 1);
            chk("b_hold_tdata", b_if.tdata, 8'h45);
            chk("b_hold_k_tready", k_if.tready, 0);
            chk("b_hold_a_tvalid", a_if.tvalid, 0);
            nxt();
        end
        b_if.tready = 1'b1;
        #1;
        chk("b_drain_tvalid", b_if.tvalid, 1);
        chk("b_drain_k_tready", k_if.tready, 1);
        nxt();
        chk("b_drain_no_dup", b_if.tvalid, 0);

        // Dropped packets consumed without backpressure; counter saturates
        a_if.tready = 1'b0;
        b_if.tready = 1'b0;
        beat(1'b1, 1'b0, 8'hC0);
        chk("drop_hdr_k_tready", k_if.tready, 1);
        nxt();
        chk("drop_count_1", drop_count, 1);
        chk("drop_a_tvalid", a_if.tvalid, 0);
        chk("drop_b_tvalid", b_if.tvalid, 0);
        beat(1'b1, 1'b1, 8'h33);
        chk("drop_body_k_tready", k_if.tready, 1);
        nxt();
        chk("drop_count_body", drop_count, 1);
        chk("drop_body_a_tvalid", a_if.tvalid, 0);
        chk("drop_body_b_tvalid", b_if.tvalid, 0);
        for (int i = 0; i < 255; i++) begin
            beat(1'b1, 1'b1, 8'(8'h80 | $urandom_range(0, 127)));
            chk("drop_many_k_tready", k_if.tready, 1);
            nxt();
            if (i == 99) chk("drop_count_101", drop_count, 101);
            if (i == 253) chk("drop_count_full", drop_count, 8'hFF);
        end
        chk("drop_count_sat", drop_count, 8'hFF);
        chk("drop_many_b_tvalid", b_if.tvalid, 0);
        beat(1'b0, 1'b0, 8'h00);

        // Back-to-back single-beat packets A then B
        a_if.tready = 1'b1;
        b_if.tready = 1'b1;
        beat(1'b1, 1'b1, 8'h01);
        nxt();
        chk("b2b_a_tvalid", a_if.tvalid, 1);
        chk("b2b_a_tdata", a_if.tdata, 8'h01);
        beat(1'b1, 1'b1, 8'h40);
        chk("b2b_k_tready", k_if.tready, 1);
        nxt();
        chk("b2b_b_tvalid", b_if.tvalid, 1);
        chk("b2b_b_tdata", b_if.tdata, 8'h40);
        chk("b2b_a_done", a_if.tvalid, 0);
        beat(1'b0, 1'b0, 8'h00);
        nxt();
        chk("b2b_b_done", b_if.tvalid, 0);

        // Same pair with A stalled: the B packet waits behind the held A beat
        a_if.tready = 1'b0;
        beat(1'b1, 1'b1, 8'h01);
        nxt();
        chk("order_a_tvalid", a_if.tvalid, 1);
        beat(1'b1, 1'b1, 8'h40);
        chk("order_k_stall", k_if.tready, 0);
        nxt();
        chk("order_a_held", a_if.tvalid, 1);
        chk("order_a_tdata", a_if.tdata, 8'h01);
        chk("order_b_waits", b_if.tvalid, 0);
        chk("order_k_stall2", k_if.tready, 0);
        a_if.tready = 1'b1;
        #1;
        chk("order_k_release", k_if.tready, 1);
        nxt();
        chk("order_b_tvalid", b_if.tvalid, 1);
        chk("order_b_tdata", b_if.tdata, 8'h40);
        chk("order_a_done", a_if.tvalid, 0);
        beat(1'b0, 1'b0, 8'h00);
        nxt();
        chk("order_b_done", b_if.tvalid, 0);

        // Reset in the middle of a B packet
        beat(1'b1, 1'b0, 8'h41);
        nxt();
        beat(1'b1, 1'b0, 8'h42);
        nxt();
        chk("midrst_b_before", b_if.tvalid, 1);
        chk("midrst_b_data", b_if.tdata, 8'h42);
        beat(1'b0, 1'b0, 8'h00);
        reset = 1'b0;
        #1;
        chk("midrst_b_tvalid", b_if.tvalid, 0);
        chk("midrst_a_tvalid", a_if.tvalid, 0);
        chk("midrst_drop_count", drop_count, 0);
        nxt();
        reset = 1'b1;
        nxt();
        beat(1'b1, 1'b1, 8'h02);
        nxt();
        chk("midrst_a_routed", a_if.tvalid, 1);
        chk("midrst_a_tdata", a_if.tdata, 8'h02);
        chk("midrst_b_quiet", b_if.tvalid, 0);
        beat(1'b0, 1'b0, 8'h00);
        nxt();

        // Randomized packets against the reference model
        for (int p = 0; p < 40; p++) begin
            len = $urandom_range(1, 4);
            hdr = 8'($urandom);
            for (int b = 0; b < len; b++) begin
                d = (b == 0) ? hdr : 8'($urandom);
                bt.d   = d;
                bt.l   = (b == len - 1);
                bt.dst = hdr[7:6];
                bt.hdr = (b == 0);
                stim.push_back(bt);
            end
        end
        si = 0;
        dc_exp = 0;
        held = 1'b0;
        pa_stall = 1'b0;
        pb_stall = 1'b0;
        pa_beat = '0;
        pb_beat = '0;
        for (cyc = 0; cyc < 4000; cyc++) begin
            if (si == stim.size() && expq.size() == 0) break;
            chk("rnd_drop_count", drop_count, dc_exp);
            if (si < stim.size() && (held || $urandom_range(0, 3) != 0)) begin
                k_if.tvalid = 1'b1;
                k_if.tlast  = stim[si].l;
                k_if.tdata  = stim[si].d;
            end else begin
                k_if.tvalid = 1'b0;
                k_if.tlast  = 1'b0;
                k_if.tdata  = 8'($urandom);
            end
            a_if.tready = ($urandom_range(0, 9) < 7);
            b_if.tready = ($urandom_range(0, 9) < 7);
            #1;
            if (pa_stall) chk("rnd_a_stable", {a_if.tvalid, a_if.tlast, a_if.tdata}, {1'b1, pa_beat});
            if (pb_stall) chk("rnd_b_stable", {b_if.tvalid, b_if.tlast, b_if.tdata}, {1'b1, pb_beat});
            chk("rnd_ab_exclusive", a_if.tvalid & b_if.tvalid, 0);
            if (a_if.tvalid && a_if.tready) begin
                chk("rnd_a_expected", expq.size() != 0, 1);
                if (expq.size() != 0) chk("rnd_a_beat", {1'b0, a_if.tlast, a_if.tdata}, expq.pop_front());
            end
            if (b_if.tvalid && b_if.tready) begin
                chk("rnd_b_expected", expq.size() != 0, 1);
                if (expq.size() != 0) chk("rnd_b_beat", {1'b1, b_if.tlast, b_if.tdata}, expq.pop_front());
            end
            ka = k_if.tvalid & k_if.tready;
            if (ka) begin
                bt = stim[si];
                if (bt.dst[1]) begin
                    if (bt.hdr) dc_exp = (dc_exp >= 255) ? 255 : dc_exp + 1;
                end else begin
                    expq.push_back({bt.dst[0], bt.l, bt.d});
                end
                si++;
                held = 1'b0;
            end else begin
                held = k_if.tvalid;
            end
            pa_stall = a_if.tvalid & ~a_if.tready;
            pb_stall = b_if.tvalid & ~b_if.tready;
            pa_beat  = {a_if.tlast, a_if.tdata};
            pb_beat  = {b_if.tlast, b_if.tdata};
            nxt();
        end
        chk("rnd_all_sent", si, stim.size());
        chk("rnd_all_drained", expq.size(), 0);
        chk("rnd_final_drop_count", drop_count, dc_exp);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
